// File: rtl/sd_dfc_relay_pkg.sv
// Elaboration-time helpers shared by the DFC relay and its storage block.
package sd_dfc_relay_pkg;

    // Pointer width for an array of the given entry count (at least one bit).
    function automatic int ptr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // Occupancy at which upstream must be told to stop so the in-flight words still fit.
    function automatic int high_water(input int entries, input int lat);
        return entries - lat;
    endfunction

endpackage

// File: rtl/sd_dfc_relay_mem.sv
// Register-array word store: synchronous write, asynchronous read, no reset on contents.
module sd_dfc_relay_mem
    import sd_dfc_relay_pkg::*;
#(
    parameter int width  = 8,
    parameter int depth  = 32,
    parameter int addr_w = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [addr_w-1:0] waddr,
    input  logic [width-1:0]  wdata,
    input  logic [addr_w-1:0] raddr,
    output logic [width-1:0]  rdata
);

    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read is combinational so the head word can be registered onto p_data in the launch cycle.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sd_dfc_relay.sv
// DFC mid-link relay: skid FIFO terminating the upstream segment, registered re-launch downstream.
module sd_dfc_relay
    import sd_dfc_relay_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 32,
    parameter int rt_lat   = 16,
    parameter int usage_sz = $clog2(depth + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c_vld,
    input  logic [width-1:0]    c_data,
    output logic                c_fc_n,
    output logic                p_vld,
    output logic [width-1:0]    p_data,
    input  logic                p_fc_n,
    output logic [usage_sz-1:0] usage,
    output logic                overflow
);

    localparam int PTR_W = ptr_width(depth);
    localparam int HWM   = high_water(depth, rt_lat);

    localparam logic [usage_sz-1:0] DEPTH_U  = usage_sz'(depth);
    localparam logic [usage_sz-1:0] HWM_U    = usage_sz'(HWM);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(depth - 1);

    if (depth <= rt_lat) begin : g_depth_check
        $error("sd_dfc_relay: depth (%0d) must exceed rt_lat (%0d)", depth, rt_lat);
    end

    if (depth < 2) begin : g_min_depth_check
        $error("sd_dfc_relay: depth (%0d) must be at least 2", depth);
    end

    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [usage_sz-1:0] usage_q, usage_d;
    logic                c_fc_n_q, c_fc_n_d;
    logic                p_vld_q, p_vld_d;
    logic [width-1:0]    p_data_q, p_data_d;
    logic                overflow_q, overflow_d;
    logic [width-1:0]    head;
    logic                launch;
    logic                write;

    sd_dfc_relay_mem #(
        .width  (width),
        .depth  (depth),
        .addr_w (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (write),
        .waddr (wptr_q),
        .wdata (c_data),
        .raddr (rptr_q),
        .rdata (head)
    );

    always_comb begin
        // p_fc_n is already registered by the downstream receiver, so it gates launch directly.
        launch = (usage_q != '0) && p_fc_n;
        // A word arriving at full still fits when the head leaves on the same edge.
        write  = c_vld && ((usage_q < DEPTH_U) || launch);

        usage_d = usage_q + usage_sz'(write) - usage_sz'(launch);

        wptr_d = wptr_q;
        if (write) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
        end

        rptr_d = rptr_q;
        if (launch) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
        end

        p_vld_d    = launch;
        p_data_d   = launch ? head : p_data_q;
        overflow_d = overflow_q | (c_vld & ~write);
        c_fc_n_d   = (usage_d < HWM_U);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            usage_q    <= '0;
            c_fc_n_q   <= 1'b0;
            p_vld_q    <= 1'b0;
            p_data_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            usage_q    <= usage_d;
            c_fc_n_q   <= c_fc_n_d;
            p_vld_q    <= p_vld_d;
            p_data_q   <= p_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign c_fc_n   = c_fc_n_q;
    assign p_vld    = p_vld_q;
    assign p_data   = p_data_q;
    assign usage    = usage_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sd_dfc_relay.sv
// Self-checking bench for sd_dfc_relay: a 32/16 instance for most scenarios, a 24/8 instance for pointer wrap.
module tb_sd_dfc_relay;

    localparam int W  = 8;
    localparam int DA = 32;
    localparam int RA = 16;
    localparam int DB = 24;
    localparam int RB = 8;
    localparam int UA = $clog2(DA + 1);
    localparam int UB = $clog2(DB + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_c_vld, a_c_fc_n, a_p_vld, a_p_fc_n, a_ovf;
    logic [W-1:0]  a_c_data, a_p_data;
    logic [UA-1:0] a_usage;
    logic          b_c_vld, b_c_fc_n, b_p_vld, b_p_fc_n, b_ovf;
    logic [W-1:0]  b_c_data, b_p_data;
    logic [UB-1:0] b_usage;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: a word queue per instance plus the expected registered outputs.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] got_a[$];
    logic [W-1:0] got_b[$];
    logic         ea_fc, ea_pvld, ea_ovf;
    logic [W-1:0] ea_pdata;
    logic         eb_fc, eb_pvld, eb_ovf;
    logic [W-1:0] eb_pdata;

    sd_dfc_relay #(.width(W), .depth(DA), .rt_lat(RA), .usage_sz(UA)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .c_vld    (a_c_vld),
        .c_data   (a_c_data),
        .c_fc_n   (a_c_fc_n),
        .p_vld    (a_p_vld),
        .p_data   (a_p_data),
        .p_fc_n   (a_p_fc_n),
        .usage    (a_usage),
        .overflow (a_ovf)
    );

    sd_dfc_relay #(.width(W), .depth(DB), .rt_lat(RB), .usage_sz(UB)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .c_vld    (b_c_vld),
        .c_data   (b_c_data),
        .c_fc_n   (b_c_fc_n),
        .p_vld    (b_p_vld),
        .p_data   (b_p_data),
        .p_fc_n   (b_p_fc_n),
        .usage    (b_usage),
        .overflow (b_ovf)
    );

    function automatic string act_a();
        return $sformatf("fc=%b vld=%b data=%h use=%0d ovf=%b", a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf);
    endfunction

    function automatic string exp_a();
        return $sformatf("fc=%b vld=%b data=%h use=%0d ovf=%b", ea_fc, ea_pvld, ea_pdata, qa.size(), ea_ovf);
    endfunction

    function automatic string act_b();
        return $sformatf("fc=%b vld=%b data=%h use=%0d ovf=%b", b_c_fc_n, b_p_vld, b_p_data, b_usage, b_ovf);
    endfunction

    function automatic string exp_b();
        return $sformatf("fc=%b vld=%b data=%h use=%0d ovf=%b", eb_fc, eb_pvld, eb_pdata, qb.size(), eb_ovf);
    endfunction

    // One clock: evaluate the relay rules on the pre-edge state, advance, sample #1 after the edge.
    task automatic tick();
        bit la, wa, lb, wb;
        la = (qa.size() != 0) && a_p_fc_n;
        wa = a_c_vld && ((qa.size() < DA) || la);
        lb = (qb.size() != 0) && b_p_fc_n;
        wb = b_c_vld && ((qb.size() < DB) || lb);
        @(posedge clk);
        #1;
        if (!rst) begin
            qa.delete(); ea_fc = 0; ea_pvld = 0; ea_pdata = '0; ea_ovf = 0;
            qb.delete(); eb_fc = 0; eb_pvld = 0; eb_pdata = '0; eb_ovf = 0;
        end else begin
            ea_pvld = la;
            if (la) ea_pdata = qa.pop_front();
            if (wa) qa.push_back(a_c_data);
            if (a_c_vld && !wa) ea_ovf = 1;
            ea_fc = (qa.size() < DA - RA);
            eb_pvld = lb;
            if (lb) eb_pdata = qb.pop_front();
            if (wb) qb.push_back(b_c_data);
            if (b_c_vld && !wb) eb_ovf = 1;
            eb_fc = (qb.size() < DB - RB);
        end
        if (a_p_vld === 1'b1) got_a.push_back(a_p_data);
        if (b_p_vld === 1'b1) got_b.push_back(b_p_data);
    endtask

    task automatic idle_inputs();
        a_c_vld = 0; a_c_data = '0; a_p_fc_n = 1;
        b_c_vld = 0; b_c_data = '0; b_p_fc_n = 1;
    endtask

    task automatic test_reset();
        #1 rst = 0;
        for (int i = 0; i < 4; i++) begin
            a_c_vld = 1'($urandom); a_c_data = W'($urandom); a_p_fc_n = 1'($urandom);
            b_c_vld = 1'($urandom); b_c_data = W'($urandom); b_p_fc_n = 1'($urandom);
            tick();
            checks++;
            if ({a_c_fc_n, a_p_vld, a_usage, a_ovf} !== '0) begin
                errors++;
                $display("FAIL reset_a i=%0d got %s want all zero", i, act_a());
            end
            checks++;
            if ({b_c_fc_n, b_p_vld, b_usage, b_ovf} !== '0) begin
                errors++;
                $display("FAIL reset_b i=%0d got %s want all zero", i, act_b());
            end
        end
        idle_inputs();
        rst = 1;
        tick();
        checks++;
        if (a_c_fc_n !== 1'b1 || a_usage !== '0) begin
            errors++;
            $display("FAIL release_a got %s want fc=1 use=0", act_a());
        end
        checks++;
        if (b_c_fc_n !== 1'b1 || b_usage !== '0) begin
            errors++;
            $display("FAIL release_b got %s want fc=1 use=0", act_b());
        end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        got_a.delete();
        a_p_fc_n = 1;
        for (int i = 0; i < 256; i++) begin
            a_c_vld = 1; a_c_data = W'(i);
            tick();
            checks++;
            if ({a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf} !== {ea_fc, ea_pvld, ea_pdata, UA'(qa.size()), ea_ovf}) begin
                errors++;
                $display("FAIL stream_model i=%0d got %s want %s", i, act_a(), exp_a());
            end
            checks++;
            if (a_usage !== UA'(1) || a_p_vld !== (i >= 1) || a_ovf !== 1'b0) begin
                errors++;
                $display("FAIL stream_steady i=%0d got use=%0d vld=%b ovf=%b want use=1 vld=%b ovf=0",
                         i, a_usage, a_p_vld, a_ovf, (i >= 1));
            end
        end
        a_c_vld = 0;
        repeat (3) tick();
        checks++;
        if (got_a.size() != 256) begin
            errors++;
            $display("FAIL stream_count got %0d want 256", got_a.size());
        end
        for (int j = 0; j < got_a.size() && j < 256; j++) begin
            checks++;
            if (got_a[j] !== W'(j)) begin
                errors++;
                $display("FAIL stream_order j=%0d got %h want %h", j, got_a[j], W'(j));
            end
        end
        $display("test_streaming done");
    endtask

    task automatic test_backpressure();
        bit hist[$];
        logic [W-1:0] sent[$];
        int peak = 0;
        got_a.delete();
        // Sender sees c_fc_n through a 16-deep delay line.
        repeat (16) hist.push_back(a_c_fc_n);
        a_p_fc_n = 0;
        for (int i = 0; i < 60; i++) begin
            a_c_vld  = hist[0] && ($urandom_range(0, 3) != 0);
            a_c_data = W'($urandom);
            if (a_c_vld) sent.push_back(a_c_data);
            tick();
            void'(hist.pop_front());
            hist.push_back(a_c_fc_n);
            checks++;
            if ({a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf} !== {ea_fc, ea_pvld, ea_pdata, UA'(qa.size()), ea_ovf}) begin
                errors++;
                $display("FAIL bp_model i=%0d got %s want %s", i, act_a(), exp_a());
            end
            checks++;
            if (a_c_fc_n !== (a_usage < UA'(DA - RA))) begin
                errors++;
                $display("FAIL bp_fc i=%0d got fc=%b at use=%0d want fc=%b", i, a_c_fc_n, a_usage, (a_usage < UA'(DA - RA)));
            end
            if (int'(a_usage) > peak) peak = int'(a_usage);
        end
        checks++;
        if (peak < DA - RA || peak > DA || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_peak got peak=%0d ovf=%b want 16..32 and ovf=0", peak, a_ovf);
        end
        a_c_vld = 0; a_p_fc_n = 1;
        repeat (40) begin
            tick();
            checks++;
            if ({a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf} !== {ea_fc, ea_pvld, ea_pdata, UA'(qa.size()), ea_ovf}) begin
                errors++;
                $display("FAIL bp_drain got %s want %s", act_a(), exp_a());
            end
        end
        checks++;
        if (got_a != sent || a_usage !== '0) begin
            errors++;
            $display("FAIL bp_order got %0d words use=%0d want %0d words use=0", got_a.size(), a_usage, sent.size());
        end
        $display("test_backpressure done");
    endtask

    task automatic test_full_launch();
        logic [W-1:0] sent[$];
        got_a.delete();
        a_p_fc_n = 0;
        for (int i = 0; i < DA; i++) begin
            a_c_vld = 1; a_c_data = W'($urandom); sent.push_back(a_c_data);
            tick();
        end
        checks++;
        if (a_usage !== UA'(DA) || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_fill got use=%0d ovf=%b want use=32 ovf=0", a_usage, a_ovf);
        end
        a_c_vld = 1; a_p_fc_n = 1; a_c_data = W'($urandom); sent.push_back(a_c_data);
        tick();
        checks++;
        if (a_usage !== UA'(DA) || a_ovf !== 1'b0 || a_p_vld !== 1'b1 || a_p_data !== sent[0]) begin
            errors++;
            $display("FAIL full_launch got %s want use=32 ovf=0 vld=1 data=%h", act_a(), sent[0]);
        end
        a_c_vld = 0;
        repeat (36) begin
            tick();
            checks++;
            if ({a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf} !== {ea_fc, ea_pvld, ea_pdata, UA'(qa.size()), ea_ovf}) begin
                errors++;
                $display("FAIL full_drain got %s want %s", act_a(), exp_a());
            end
        end
        checks++;
        if (got_a != sent) begin
            errors++;
            $display("FAIL full_order got %0d words want %0d", got_a.size(), sent.size());
        end
        $display("test_full_launch done");
    endtask

    task automatic test_overflow();
        logic [W-1:0] sent[$];
        got_a.delete();
        a_p_fc_n = 0;
        for (int i = 0; i < DA + 1; i++) begin
            a_c_vld = 1; a_c_data = W'($urandom); sent.push_back(a_c_data);
            tick();
            checks++;
            if (a_ovf !== (i == DA) || a_usage !== UA'((i < DA) ? i + 1 : DA)) begin
                errors++;
                $display("FAIL ovf_fill i=%0d got use=%0d ovf=%b want use=%0d ovf=%b",
                         i, a_usage, a_ovf, (i < DA) ? i + 1 : DA, (i == DA));
            end
        end
        a_c_vld = 0; a_p_fc_n = 1;
        repeat (36) begin
            tick();
            checks++;
            if ({a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf} !== {ea_fc, ea_pvld, ea_pdata, UA'(qa.size()), ea_ovf}) begin
                errors++;
                $display("FAIL ovf_drain got %s want %s", act_a(), exp_a());
            end
        end
        checks++;
        if (got_a.size() != DA || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got words=%0d ovf=%b want words=32 ovf=1", got_a.size(), a_ovf);
        end
        for (int j = 0; j < DA && j < got_a.size(); j++) begin
            checks++;
            if (got_a[j] !== sent[j]) begin
                errors++;
                $display("FAIL ovf_order j=%0d got %h want %h", j, got_a[j], sent[j]);
            end
        end
        $display("test_overflow done");
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] sent[$];
        a_p_fc_n = 0;
        repeat (10) begin
            a_c_vld = 1; a_c_data = W'($urandom);
            tick();
        end
        a_c_vld = 0;
        rst = 0;
        #1;
        checks++;
        if ({a_c_fc_n, a_p_vld, a_p_data, a_usage, a_ovf} !== '0) begin
            errors++;
            $display("FAIL midrst_async got %s want all zero", act_a());
        end
        tick();
        rst = 1;
        got_a.delete();
        a_p_fc_n = 1;
        for (int i = 0; i < 5; i++) begin
            a_c_vld = 1; a_c_data = W'($urandom); sent.push_back(a_c_data);
            tick();
        end
        a_c_vld = 0;
        repeat (4) tick();
        checks++;
        if (got_a != sent || a_usage !== '0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrst_resume got words=%0d use=%0d ovf=%b want words=5 use=0 ovf=0",
                     got_a.size(), a_usage, a_ovf);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_wrap();
        bit hist[$];
        logic [W-1:0] sent[$];
        got_b.delete();
        repeat (8) hist.push_back(b_c_fc_n);
        for (int cyc = 0; cyc < 4000 && sent.size() < 500; cyc++) begin
            b_p_fc_n = 1'($urandom_range(0, 1));
            b_c_vld  = hist[0];
            b_c_data = W'($urandom);
            if (b_c_vld) sent.push_back(b_c_data);
            tick();
            void'(hist.pop_front());
            hist.push_back(b_c_fc_n);
            checks++;
            if ({b_c_fc_n, b_p_vld, b_p_data, b_usage, b_ovf} !== {eb_fc, eb_pvld, eb_pdata, UB'(qb.size()), eb_ovf}) begin
                errors++;
                $display("FAIL wrap_model cyc=%0d got %s want %s", cyc, act_b(), exp_b());
            end
        end
        checks++;
        if (sent.size() != 500) begin
            errors++;
            $display("FAIL wrap_timeout got %0d words sent want 500", sent.size());
        end
        b_c_vld = 0; b_p_fc_n = 1;
        repeat (30) tick();
        checks++;
        if (got_b != sent || b_ovf !== 1'b0 || b_usage !== '0) begin
            errors++;
            $display("FAIL wrap_order got words=%0d ovf=%b use=%0d want words=%0d ovf=0 use=0",
                     got_b.size(), b_ovf, b_usage, sent.size());
        end
        $display("test_wrap done");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_launch();
        test_overflow();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
